// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the memory-mapped UART receiver:
//   - rx_state_t     : receiver FSM states
//   - UART_BASE      : base of the UART register block (transmit register)
//   - UART_DATA_OFS  : offset of the receive DATA register from UART_BASE
//   - UART_STAT_OFS  : offset of the receive STATUS register from UART_BASE
//   - STAT_*_BIT     : bit positions inside the STATUS word
//   - status_word()  : packs the status flags into a 32-bit read value
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam logic [31:0] UART_BASE     = 32'h0000_1000;
   localparam logic [31:0] UART_DATA_OFS = 32'd4;
   localparam logic [31:0] UART_STAT_OFS = 32'd8;

   localparam int STAT_VALID_BIT = 0;
   localparam int STAT_FERR_BIT  = 1;
   localparam int STAT_OVR_BIT   = 2;

   // Firmware polls this word, so the bit layout must stay fixed.
   function automatic logic [31:0] status_word(input logic ovr,
                                               input logic ferr,
                                               input logic valid);
      logic [31:0] w;
      w                 = '0;
      w[STAT_OVR_BIT]   = ovr;
      w[STAT_FERR_BIT]  = ferr;
      w[STAT_VALID_BIT] = valid;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if
// Load-side bus between the core and the UART receiver.
//   ren      : core load strobe, qualifies addr
//   addr     : 32-bit byte address, full-word compare
//   rdata    : 32-bit read data, combinational from addr/ren
//   rx_valid : receive FIFO non-empty
// Modports: master = core side, slave = UART side.
interface uart_rx_mmio_if;

   logic        ren;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        rx_valid;

   modport master (output ren, output addr, input rdata, input rx_valid);
   modport slave  (input ren, input addr, output rdata, output rx_valid);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a show-ahead head output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : current head entry (meaningless while empty)
//   empty,full : occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit tells a full FIFO apart from an empty one when
   // the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   uart_in    : asynchronous serial line, idles high
//   bus        : load-side bus (ren, addr -> rdata, rx_valid)
// Registers: BASE_ADDR = DATA (read pops one byte),
//            BASE_ADDR+4 = STATUS {ovr, ferr, rx_valid} (read clears flags).
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int          WAIT_DIV   = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = UART_BASE + UART_DATA_OFS
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           uart_in,
   uart_rx_mmio_if.slave  bus
);

   localparam int               CNT_W     = $clog2(WAIT_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(WAIT_DIV / 2 - 1);
   localparam logic [31:0]      STAT_ADDR = BASE_ADDR + (UART_STAT_OFS - UART_DATA_OFS);

   logic             sync_q;
   logic             rxs;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shreg;
   logic             ovr;
   logic             ferr;
   logic [7:0]       fifo_dout;
   logic             fifo_empty;
   logic             fifo_full;
   logic             bit_end;
   logic             push_req;
   logic             ferr_set;
   logic             ovr_set;
   logic             data_hit;
   logic             stat_hit;
   logic [31:0]      rdata_c;

   // Two-flop synchronizer; both stages reset to the idle (high) level so
   // reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         sync_q <= uart_in;
         rxs    <= sync_q;
      end
   end

   assign bit_end  = (cnt == CNT_LAST);
   assign push_req = (state == STOP) && bit_end && rxs;
   assign ferr_set = (state == STOP) && bit_end && !rxs;
   assign data_hit = bus.ren && (bus.addr == BASE_ADDR);
   assign stat_hit = bus.ren && (bus.addr == STAT_ADDR);
   // A pop in the same cycle frees the slot, so a full FIFO only overruns
   // when nobody reads DATA at the stop-sample edge.
   assign ovr_set  = push_req && fifo_full && !data_hit;

   // Receiver FSM. START waits half a bit to land on the start-bit centre;
   // every later sample is a whole bit period after the previous one.
   // BREAK swallows a held-low line so it is not taken as a new start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shreg[idx] <= rxs;
                  cnt        <= '0;
                  if (idx == 3'd7) state <= STOP;
                  else             idx   <= idx + 3'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= rxs ? IDLE : BREAK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error flags: a set event in the same cycle as a STATUS read
   // wins, so the error is never lost between two polls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (ovr_set)       ovr <= 1'b1;
         else if (stat_hit) ovr <= 1'b0;
         if (ferr_set)       ferr <= 1'b1;
         else if (stat_hit)  ferr <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (data_hit),
      .din   (shreg),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Read mux. DATA returns 0 while empty, even if a byte is being pushed
   // in the same cycle.
   always_comb begin
      rdata_c = '0;
      if (data_hit && !fifo_empty) begin
         rdata_c = {24'b0, fifo_dout};
      end else if (stat_hit) begin
         rdata_c = status_word(ovr, ferr, !fifo_empty);
      end
   end

   assign bus.rdata    = rdata_c;
   assign bus.rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio
// Self-checking bench for uart_rx_mmio: table-driven register reads after
// directed frames, hand-timed corner cases, and randomized frames checked
// against a queue-based reference model of the receive FIFO and flags.
module tb_uart_rx_mmio;

   localparam int          W         = 8;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] DATA_ADDR = 32'h0000_1004;
   localparam logic [31:0] STAT_ADDR = 32'h0000_1008;
   localparam logic [31:0] TX_ADDR   = 32'h0000_1000;

   typedef struct {
      logic        ren;
      logic [31:0] addr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic clk;
   logic rst_n;
   logic uart_in;
   int   checks;
   int   failures;

   uart_rx_mmio_if bus_if ();

   uart_rx_mmio #(
      .WAIT_DIV   (W),
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (DATA_ADDR)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .uart_in (uart_in),
      .bus     (bus_if.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Equality comparison with failure reporting
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One bus read: drive at negedge, compare rdata in the same cycle, keep
   // ren across the following posedge so the side effect happens.
   task automatic applyStimulus(input logic ren_v, input logic [31:0] addr_v,
                                input logic [31:0] exp, input string name);
      @(negedge clk);
      bus_if.ren  = ren_v;
      bus_if.addr = addr_v;
      #1;
      checkOutput(name, bus_if.rdata, exp);
      @(negedge clk);
      bus_if.ren  = 1'b0;
      bus_if.addr = '0;
   endtask

   // Serial frame, caller is at a negedge; each bit lasts W cycles. The line
   // is left at the stop level when the task returns.
   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      uart_in = 1'b0;
      repeat (W) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_in = b[i];
         repeat (W) @(negedge clk);
      end
      uart_in = stop_v;
      repeat (W) @(negedge clk);
   endtask

   task automatic run_table(input vec_t tbl[], input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].ren, tbl[i].addr, tbl[i].exp, {tag, "_", tbl[i].name});
      end
   endtask

   // Reference model state
   logic [7:0] m_q[$];
   logic       m_ovr;
   logic       m_ferr;

   function automatic logic [31:0] model_status();
      return {29'b0, m_ovr, m_ferr, (m_q.size() != 0)};
   endfunction

   initial begin
      vec_t        tbl_single[];
      vec_t        tbl_burst[];
      logic [7:0]  burst[6];
      int          cyc;
      // Stop-sample edge counted from the posedge that first sees the start
      // bit: 2 synchronizer edges + 1 to enter START, W/2 for the start-bit
      // centre, then 9 whole bits.
      int          stop_edge;

      stop_edge = 3 + W / 2 + 9 * W;

      tbl_single = new[6];
      tbl_single[0] = '{1'b1, STAT_ADDR, 32'h1,  "stat_valid"};
      tbl_single[1] = '{1'b0, DATA_ADDR, 32'h0,  "ren_low"};
      tbl_single[2] = '{1'b1, TX_ADDR,   32'h0,  "tx_addr"};
      tbl_single[3] = '{1'b1, DATA_ADDR, 32'h41, "data"};
      tbl_single[4] = '{1'b1, STAT_ADDR, 32'h0,  "stat_after"};
      tbl_single[5] = '{1'b1, DATA_ADDR, 32'h0,  "data_empty"};

      burst = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h0d};
      tbl_burst = new[7];
      tbl_burst[0] = '{1'b1, STAT_ADDR, 32'h5,  "stat_ovr"};
      tbl_burst[1] = '{1'b1, DATA_ADDR, 32'h68, "d0"};
      tbl_burst[2] = '{1'b1, DATA_ADDR, 32'h65, "d1"};
      tbl_burst[3] = '{1'b1, DATA_ADDR, 32'h6c, "d2"};
      tbl_burst[4] = '{1'b1, DATA_ADDR, 32'h6c, "d3"};
      tbl_burst[5] = '{1'b1, DATA_ADDR, 32'h0,  "d_empty"};
      tbl_burst[6] = '{1'b1, STAT_ADDR, 32'h0,  "stat_clear"};

      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      uart_in     = 1'b1;
      bus_if.ren  = 1'b0;
      bus_if.addr = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_rx_valid", {31'b0, bus_if.rx_valid}, 32'h0);
      checkOutput("reset_rdata", bus_if.rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "reset_status");

      // Single byte with frame-to-valid latency
      $display("[TB] single byte");
      cyc = 0;
      fork
         send_frame(8'h41, 1'b1);
         begin
            while (!bus_if.rx_valid && cyc < 200) begin
               @(posedge clk);
               cyc++;
               #1;
            end
         end
      join
      checks++;
      if (cyc < 76 || cyc > 80) begin
         failures++;
         $display("[TB] FAIL frame_to_valid: got %0d cycles expected 76..80", cyc);
      end
      run_table(tbl_single, "single");

      // Back-to-back burst overflowing the FIFO
      $display("[TB] burst");
      foreach (burst[i]) send_frame(burst[i], 1'b1);
      repeat (2 * W) @(negedge clk);
      run_table(tbl_burst, "burst");

      // Short glitch must not start a frame
      $display("[TB] glitch");
      uart_in = 1'b0;
      repeat (2) @(negedge clk);
      uart_in = 1'b1;
      repeat (2 * W) @(negedge clk);
      checkOutput("glitch_valid", {31'b0, bus_if.rx_valid}, 32'h0);
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "glitch_status");

      // Framing error, STATUS read in the very cycle ferr sets
      $display("[TB] framing error");
      fork
         send_frame(8'h74, 1'b0);
         begin
            repeat (stop_edge - 1) @(posedge clk);
            applyStimulus(1'b1, STAT_ADDR, 32'h0, "ferr_race_read");
         end
      join
      repeat (20 * W) @(negedge clk);
      uart_in = 1'b1;
      repeat (2 * W) @(negedge clk);
      applyStimulus(1'b1, STAT_ADDR, 32'h2, "ferr_status");
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "ferr_cleared");
      send_frame(8'h0d, 1'b1);
      repeat (2 * W) @(negedge clk);
      applyStimulus(1'b1, STAT_ADDR, 32'h1, "after_ferr_status");
      applyStimulus(1'b1, DATA_ADDR, 32'h0d, "after_ferr_data");

      // Full FIFO with a pop exactly at the stop-sample edge
      $display("[TB] full with pop");
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      repeat (2 * W) @(negedge clk);
      applyStimulus(1'b1, STAT_ADDR, 32'h1, "full_status");
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (stop_edge - 1) @(posedge clk);
            applyStimulus(1'b1, DATA_ADDR, 32'h11, "full_pop_race");
         end
      join
      repeat (2 * W) @(negedge clk);
      applyStimulus(1'b1, STAT_ADDR, 32'h1, "full_no_ovr");
      applyStimulus(1'b1, DATA_ADDR, 32'h22, "full_d0");
      applyStimulus(1'b1, DATA_ADDR, 32'h33, "full_d1");
      applyStimulus(1'b1, DATA_ADDR, 32'h44, "full_d2");
      applyStimulus(1'b1, DATA_ADDR, 32'h55, "full_d3");
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "full_drained");

      // Reset during data bit 4, with an older byte still buffered
      $display("[TB] reset mid-frame");
      send_frame(8'h33, 1'b1);
      repeat (2 * W) @(negedge clk);
      checkOutput("prereset_valid", {31'b0, bus_if.rx_valid}, 32'h1);
      fork
         send_frame(8'h65, 1'b1);
         begin
            repeat (5 * W + W / 2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            checkOutput("midreset_valid", {31'b0, bus_if.rx_valid}, 32'h0);
            checkOutput("midreset_rdata", bus_if.rdata, 32'h0);
         end
      join
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W) @(negedge clk);
      send_frame(8'h78, 1'b1);
      repeat (2 * W) @(negedge clk);
      applyStimulus(1'b1, STAT_ADDR, 32'h1, "postreset_status");
      applyStimulus(1'b1, DATA_ADDR, 32'h78, "postreset_data");
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "postreset_clear");

      // Randomized frames and reads against the reference model
      $display("[TB] random");
      m_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      for (int f = 0; f < 14; f++) begin
         logic [7:0] b;
         logic       bad;
         int         nreads;
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 4) == 0);
         send_frame(b, !bad);
         if (bad) begin
            repeat (2 * W) @(negedge clk);
            uart_in = 1'b1;
            m_ferr  = 1'b1;
         end else if (m_q.size() < DEPTH) begin
            m_q.push_back(b);
         end else begin
            m_ovr = 1'b1;
         end
         repeat (2 * W) @(negedge clk);
         checkOutput("rnd_valid", {31'b0, bus_if.rx_valid}, {31'b0, (m_q.size() != 0)});
         nreads = $urandom_range(0, 3);
         for (int r = 0; r < nreads; r++) begin
            if ($urandom_range(0, 1) == 0) begin
               applyStimulus(1'b1, DATA_ADDR, (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'h0, "rnd_data");
               if (m_q.size() != 0) void'(m_q.pop_front());
            end else begin
               applyStimulus(1'b1, STAT_ADDR, model_status(), "rnd_status");
               m_ovr  = 1'b0;
               m_ferr = 1'b0;
            end
         end
      end
      applyStimulus(1'b1, STAT_ADDR, model_status(), "rnd_final_status");
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      while (m_q.size() != 0) begin
         applyStimulus(1'b1, DATA_ADDR, {24'b0, m_q[0]}, "rnd_drain");
         void'(m_q.pop_front());
      end
      applyStimulus(1'b1, DATA_ADDR, 32'h0, "rnd_drain_empty");
      applyStimulus(1'b1, STAT_ADDR, 32'h0, "rnd_end_status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
